// File: rtl/pll_lock_supervisor.sv
// Purpose : sequences PLL reset, waits for lock with timeout/retries, qualifies lock and releases the core reset.
// Latency : pll_locked reaches the FSM after 2 sync flops; every output is registered one edge after the decision.
// Backpress: none; free-running supervisor on refclk, no handshakes.
//
// Ports:
//   refclk          50 MHz reference clock (sole clock)
//   rst             asynchronous active-high reset
//   pll_locked      PLL lock indicator, asynchronous to refclk
//   pll_rst         active-high reset to the PLL
//   sys_rst         active-high reset to the processor core
//   ready           high only while the PLL is locked and qualified (RUN)
//   fail            high only after RETRY_MAX failed attempts (FAIL)
//   retry_count     failed lock attempts since the last RUN entry
//   lock_loss_count RUN->PRST transitions, saturating at 255 (only with LOCK_LOSS_COUNT_EN)
//
// Build option: define LOCK_LOSS_COUNT_EN to add the lock_loss_count output.
module pll_lock_supervisor #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RETRY_MAX           = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_count
`ifdef LOCK_LOSS_COUNT_EN
  ,
  output logic [7:0] lock_loss_count
`endif
);

  localparam int MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_PULSE_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CNT = (MAX_A > LOCK_STABLE_CYCLES) ? MAX_A : LOCK_STABLE_CYCLES;
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock_s already counts as one stable
  // sample, so STABLE needs one fewer cycle; a one-cycle requirement skips STABLE.
  localparam bit               STABLE_SKIP  = (LOCK_STABLE_CYCLES <= 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = STABLE_SKIP ? '0 : CNT_W'(LOCK_STABLE_CYCLES - 2);
  localparam logic [3:0]       RETRY_LIM    = 4'(RETRY_MAX);

  typedef enum logic [2:0] {
    S_PRST      = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       retry_q, retry_d;
  logic [3:0]       retry_inc;
  logic             sync1_q, lock_s_q;
  logic             pll_rst_q, sys_rst_q, ready_q, fail_q;
`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0]       loss_q, loss_d;
`endif

  assign retry_inc = retry_q + 4'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    retry_d = retry_q;
`ifdef LOCK_LOSS_COUNT_EN
    loss_d  = loss_q;
`endif
    case (state_q)
      S_PRST: begin
        if (cnt_q == PULSE_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s_q) begin
          state_d = STABLE_SKIP ? S_RUN : S_STABLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          state_d = (retry_inc == RETRY_LIM) ? S_FAIL : S_PRST;
        end
      end
      S_STABLE: begin
        if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s_q) begin
          state_d = S_PRST;
`ifdef LOCK_LOSS_COUNT_EN
          if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
`endif
        end
      end
      S_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = S_PRST;
      end
    endcase
    if ((state_d == S_RUN) && (state_q != S_RUN)) retry_d = '0;
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_PRST;
      cnt_q     <= '0;
      retry_q   <= '0;
      sync1_q   <= 1'b0;
      lock_s_q  <= 1'b0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
`ifdef LOCK_LOSS_COUNT_EN
      loss_q    <= '0;
`endif
    end else begin
      sync1_q   <= pll_locked;
      lock_s_q  <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      // Outputs decoded from next state so they line up with the state register.
      pll_rst_q <= (state_d == S_PRST) || (state_d == S_FAIL);
      sys_rst_q <= (state_d != S_RUN);
      ready_q   <= (state_d == S_RUN);
      fail_q    <= (state_d == S_FAIL);
`ifdef LOCK_LOSS_COUNT_EN
      loss_q    <= loss_d;
`endif
    end
  end

  assign pll_rst     = pll_rst_q;
  assign sys_rst     = sys_rst_q;
  assign ready       = ready_q;
  assign fail        = fail_q;
  assign retry_count = retry_q;
`ifdef LOCK_LOSS_COUNT_EN
  assign lock_loss_count = loss_q;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Purpose : self-checking bench for pll_lock_supervisor against a phase/streak reference model.
// Latency : outputs sampled 1 time unit after each rising refclk edge.
// Backpress: none.
module tb_pll_lock_supervisor;

  localparam int RP = 4;
  localparam int TO = 20;
  localparam int ST = 8;
  localparam int RM = 3;

  // Reference model phases: acquisition is one phase tracked by a lock streak.
  localparam int PH_PULSE  = 0;
  localparam int PH_ACQ    = 1;
  localparam int PH_RUN    = 2;
  localparam int PH_FAILED = 3;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       pll_rst, sys_rst, ready, fail;
  logic [3:0] retry_count;
`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] lock_loss_count;
`endif

  int checks = 0;
  int failures = 0;

  int m_phase, m_pulse_left, m_streak, m_waited, m_retries, m_losses;
  bit m_sync[$];

  pll_lock_supervisor #(
    .RST_PULSE_CYCLES   (RP),
    .LOCK_TIMEOUT_CYCLES(TO),
    .LOCK_STABLE_CYCLES (ST),
    .RETRY_MAX          (RM)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .pll_rst    (pll_rst),
    .sys_rst    (sys_rst),
    .ready      (ready),
    .fail       (fail),
    .retry_count(retry_count)
`ifdef LOCK_LOSS_COUNT_EN
    ,
    .lock_loss_count(lock_loss_count)
`endif
  );

  always #10 refclk = ~refclk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase      = PH_PULSE;
    m_pulse_left = RP;
    m_streak     = 0;
    m_waited     = 0;
    m_retries    = 0;
    m_losses     = 0;
    m_sync       = '{1'b0, 1'b0};
  endtask

  // One refclk edge: 'sample' is what pll_locked showed at this edge; the
  // controller acts on the sample taken two edges earlier.
  task automatic model_edge(input bit sample);
    bit seen;
    seen = m_sync.pop_front();
    m_sync.push_back(sample);
    case (m_phase)
      PH_PULSE: begin
        m_pulse_left--;
        if (m_pulse_left == 0) begin
          m_phase  = PH_ACQ;
          m_streak = 0;
          m_waited = 0;
        end
      end
      PH_ACQ: begin
        if (seen) begin
          m_streak++;
          if (m_streak == ST) begin
            m_phase   = PH_RUN;
            m_retries = 0;
          end
        end else if (m_streak > 0) begin
          m_streak = 0;
          m_waited = 0;
        end else begin
          m_waited++;
          if (m_waited == TO) begin
            m_retries++;
            if (m_retries == RM) m_phase = PH_FAILED;
            else begin
              m_phase      = PH_PULSE;
              m_pulse_left = RP;
            end
          end
        end
      end
      PH_RUN: begin
        if (!seen) begin
          m_phase      = PH_PULSE;
          m_pulse_left = RP;
          if (m_losses < 255) m_losses++;
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [7:0] exp_vec();
    logic p, s, r, f;
    p = (m_phase == PH_PULSE) || (m_phase == PH_FAILED);
    s = (m_phase != PH_RUN);
    r = (m_phase == PH_RUN);
    f = (m_phase == PH_FAILED);
    return {p, s, r, f, 4'(m_retries)};
  endfunction

  task automatic step(input logic lk);
    pll_locked = lk;
    @(posedge refclk);
    if (rst) model_reset();
    else model_edge(lk);
    #1;
    chk("outs", int'({pll_rst, sys_rst, ready, fail, retry_count}), int'(exp_vec()));
`ifdef LOCK_LOSS_COUNT_EN
    chk("loss_cnt", int'(lock_loss_count), m_losses);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (3) step(1'b0);
    rst = 1'b0;
  endtask

  initial begin
    int fall_pr, fall_sr, rise2, r_mid, cnt_pr;
    logic lvl;
    int len;

    // Reset values
    do_reset();
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_sys_rst", sys_rst, 1);
    chk("rst_status", int'({ready, fail, retry_count}), 0);

    // 1: nominal lock
    fall_pr = 0; fall_sr = 0;
    for (int e = 1; e <= 40; e++) begin
      step(e > 10);
      if (fall_pr == 0 && !pll_rst) fall_pr = e;
      if (fall_sr == 0 && !sys_rst) fall_sr = e;
    end
    chk("s1_prst_len", fall_pr, RP);
    chk("s1_sysrst_fall", fall_sr, 20);
    chk("s1_ready", ready, 1);
    chk("s1_retry", retry_count, 0);

    // 2: one timeout then lock
    do_reset();
    rise2 = 0; r_mid = -1;
    for (int e = 1; e <= 80; e++) begin
      step(e >= 34);
      if (rise2 == 0 && e > RP && pll_rst) rise2 = e;
      if (e == 30) r_mid = retry_count;
    end
    chk("s2_retry_pulse", rise2, RP + TO);
    chk("s2_retry_mid", r_mid, 1);
    chk("s2_ready", ready, 1);
    chk("s2_retry_clr", retry_count, 0);

    // 3: permanent failure, held, then cleared by rst
    do_reset();
    for (int e = 1; e <= RM * (RP + TO) + 1000; e++) step(1'b0);
    chk("s3_fail", fail, 1);
    chk("s3_pll_rst", pll_rst, 1);
    chk("s3_sys_rst", sys_rst, 1);
    chk("s3_retry", retry_count, RM);
    rst = 1'b1;
    step(1'b0);
    chk("s3_fail_clr", fail, 0);
    rst = 1'b0;
    step(1'b0);
    chk("s3_restart", int'({pll_rst, fail}), 2);

    // 4: unstable lock restarts qualification without a retry
    do_reset();
    fall_sr = 0;
    for (int e = 1; e <= 50; e++) begin
      step((e >= 11 && e <= 15) || e >= 17);
      if (fall_sr == 0 && !sys_rst) fall_sr = e;
    end
    chk("s4_sysrst_fall", fall_sr, 26);
    chk("s4_retry", retry_count, 0);

    // 5: lock loss while running
    fall_sr = 0; cnt_pr = 0;
    for (int i = 1; i <= 15; i++) begin
      step(1'b0);
      if (fall_sr == 0 && sys_rst) fall_sr = i;
      if (pll_rst) cnt_pr++;
    end
    chk("s5_loss_delay", fall_sr, 3);
    chk("s5_pulse_len", cnt_pr, RP);
    chk("s5_ready", ready, 0);
`ifdef LOCK_LOSS_COUNT_EN
    chk("s5_loss_count", lock_loss_count, 1);
`endif

    // 6: async reset in the middle of the stability count
    do_reset();
    for (int e = 1; e <= 10; e++) step(1'b1);
    #4;
    rst = 1'b1;
    #1;
    chk("s6_async_pll_rst", pll_rst, 1);
    chk("s6_async_sys_rst", sys_rst, 1);
    chk("s6_async_status", int'({ready, fail, retry_count}), 0);
    model_reset();
    step(1'b1);
    rst = 1'b0;
    fall_pr = 0;
    for (int e = 1; e <= 30; e++) begin
      step(1'b1);
      if (fall_pr == 0 && !pll_rst) fall_pr = e;
    end
    chk("s6_prst_restart", fall_pr, RP);

    // Randomized lock patterns with occasional resets
    do_reset();
    for (int seg = 0; seg < 120; seg++) begin
      lvl = ($urandom_range(0, 3) != 0);
      len = lvl ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 30));
      if (m_phase == PH_FAILED || $urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        step(lvl);
        rst = 1'b0;
      end
      for (int i = 0; i < len; i++) step(lvl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Drives the PLL's active-high `rst` input and consumes its `locked` output.
- Sequences PLL reset, waits for lock with a timeout and bounded retries, and qualifies lock stability.
- Produces a clean system reset for the processor core.
- Runs on the 50 MHz reference clock, which stays valid while the PLL outputs are unstable.

Parameters:
- RST_PULSE_CYCLES, 16, cycles `pll_rst` is held high per reset attempt (min 1)
- LOCK_TIMEOUT_CYCLES, 50000, max cycles in WAIT_LOCK before the attempt counts as failed (1 ms at 50 MHz)
- LOCK_STABLE_CYCLES, 1024, consecutive synced-lock cycles required before system reset is released
- RETRY_MAX, 3, failed lock attempts allowed before entering FAIL (1..15)

Ports:
- refclk  in  1  50 MHz reference clock; sole clock of the block
- rst  in  1  asynchronous, active-high reset
- pll_locked  in  1  PLL `locked`; asynchronous to `refclk`
- pll_rst  out  1  drives PLL `rst`; active-high
- sys_rst  out  1  active-high reset to the processor core; registered
- ready  out  1  high only in RUN
- fail  out  1  high only in FAIL
- retry_count  out  4  failed lock attempts since the last RUN entry

Behaviour:
- Interface (already decided): one clock, `refclk`. `rst` is asynchronous and active-high.
- Reset values: `pll_rst`=1, `sys_rst`=1, `ready`=0, `fail`=0, `retry_count`=0, state=PRST, all counters 0, sync flops 0.
- `pll_locked` passes through a 2-flop synchronizer to `lock_s`, so `lock_s` lags `pll_locked` by 2 refclk edges.
- One shared cycle counter `cnt`, cleared on every state transition. Width is clog2 of the largest count parameter.
- All outputs are registered, driven from next-state (Moore on registered state).
- State PRST:
  - `pll_rst`=1, `sys_rst`=1.
  - Stays RST_PULSE_CYCLES cycles, then goes to WAIT_LOCK.
- State WAIT_LOCK:
  - `pll_rst`=0, `sys_rst`=1.
  - `lock_s`=1 → STABLE.
  - Otherwise, when `cnt`==LOCK_TIMEOUT_CYCLES-1: `retry_count`++.
    - If the incremented value == RETRY_MAX → FAIL.
    - Otherwise → PRST.
  - If lock and timeout occur in the same cycle, lock wins (→ STABLE, no increment).
- State STABLE:
  - `pll_rst`=0, `sys_rst`=1.
  - `lock_s`=0 → WAIT_LOCK, timeout counter restarts. This is not a retry.
  - After LOCK_STABLE_CYCLES consecutive cycles with `lock_s`=1 → RUN.
- State RUN:
  - `pll_rst`=0, `sys_rst`=0, `ready`=1.
  - `retry_count` clears on entry.
  - `lock_s`=0 → PRST. `sys_rst`=1 and `ready`=0 on the next edge.
  - Lock loss is not counted as a retry.
- State FAIL:
  - `pll_rst`=1 (PLL held in reset), `sys_rst`=1, `fail`=1.
  - `retry_count` holds RETRY_MAX.
  - Exited only by `rst`.
- `rst` asserted in any state, including mid-pulse or mid-stable count: immediate return to reset values, and `pll_rst` goes high asynchronously.
- After `rst` deasserts, the PRST pulse restarts from `cnt`=0.
- `retry_count` never wraps; it saturates at RETRY_MAX by construction.
- Glitches on `pll_locked` shorter than 1 refclk may be missed. This is accepted behaviour.

Optional Feature:
- Macro: LOCK_LOSS_COUNT_EN.
- When defined:
  - Adds output `lock_loss_count` [7:0], reset 0.
  - Increments on each RUN→PRST transition and saturates at 255.
  - Cleared only by `rst`.
- When undefined:
  - The port and counter do not exist.
  - All other behaviour is identical.

Test Plan:
Bench parameters: RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8, RETRY_MAX=3.
1. Nominal lock: `rst` high 3 cycles then low; `pll_locked` rises 10 cycles after release → `pll_rst` high exactly 4 cycles after release; `sys_rst` falls 8 cycles after `lock_s` first high; `ready`=1; `retry_count`=0.
2. Timeout retry: `pll_locked` held 0 for the first attempt, then raised 5 cycles into the second WAIT_LOCK → second `pll_rst` pulse after 20 WAIT_LOCK cycles; `retry_count`=1 until RUN, then 0.
3. Permanent fail: `pll_locked`=0 forever → 3 PRST/WAIT_LOCK cycles, then `fail`=1, `pll_rst`=1, `sys_rst`=1, `retry_count`=3, held for 1000 cycles; pulsing `rst` clears `fail` and restarts PRST.
4. Unstable lock: `pll_locked` high 5 cycles, low 1 cycle, high again → returns to WAIT_LOCK with no retry increment; `sys_rst` stays 1 until 8 clean cycles accumulate.
5. Lock loss in RUN: drop `pll_locked` → `sys_rst`=1 and `ready`=0 exactly 3 edges later (2 sync + 1 register); new 4-cycle `pll_rst` pulse follows; with LOCK_LOSS_COUNT_EN, `lock_loss_count`=1.
6. Async reset mid-STABLE: assert `rst` between edges at `cnt`=5 → `pll_rst`=1 and `sys_rst`=1 before the next edge; all status outputs at reset values.
